// File: rtl/maxnet_controller_if.sv
// Control bundle between the maxnet controller and the 4-PU winner-take-all
// datapath: run request, per-PU zero flags, end signal, enables and result.
interface maxnet_controller_if;
    logic       start;
    logic       z0;
    logic       z1;
    logic       z2;
    logic       z3;
    logic       end_signal;
    logic       b_regs_en;
    logic       a_regs_en;
    logic       a_muxs;
    logic       pu_mult_regs_en;
    logic       pu_add_regs_en;
    logic [1:0] res_mux;
    logic       done;
    logic       busy;
    logic       fail;

    // Controller side: consumes status, drives every enable/select.
    modport master (
        input  start, z0, z1, z2, z3, end_signal,
        output b_regs_en, a_regs_en, a_muxs, pu_mult_regs_en, pu_add_regs_en,
               res_mux, done, busy, fail
    );

    // Datapath / requester side.
    modport slave (
        output start, z0, z1, z2, z3, end_signal,
        input  b_regs_en, a_regs_en, a_muxs, pu_mult_regs_en, pu_add_regs_en,
               res_mux, done, busy, fail
    );
endinterface

// File: rtl/maxnet_controller.sv
// Control FSM for the 4-PU winner-take-all datapath: loads the candidates,
// iterates multiply/add/update until one survivor remains (or the iteration
// budget runs out), then presents the winning PU index.
module maxnet_controller #(
    parameter int MAX_ITER = 15,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,   // asynchronous, active-low
    maxnet_controller_if.master  ctl
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_MULT,
        S_ADD,
        S_CHECK,
        S_DONE
    } state_t;

    // Counter value at the last permitted CHECK evaluation.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_ITER - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       res_mux_q, res_mux_d;
    logic             fail_q, fail_d;

    logic             timeout;
    logic             all_zero;
    logic [1:0]       winner;

    assign timeout = (cnt_q == LAST_CNT);

    // Priority pick of the lowest-index PU whose output is still non-zero.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        winner   = 2'd0;
        all_zero = 1'b0;
        if (!ctl.z0)      winner = 2'd0;
        else if (!ctl.z1) winner = 2'd1;
        else if (!ctl.z2) winner = 2'd2;
        else if (!ctl.z3) winner = 2'd3;
        else              all_zero = 1'b1;
    end

    // State register plus iteration counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            res_mux_q <= 2'd0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_mux_q <= res_mux_d;
            fail_q    <= fail_d;
        end
    end

    // Next-state logic: sequencing, iteration counting and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_mux_d = res_mux_q;
        fail_d    = fail_q;
        case (state_q)
            S_IDLE: begin
                if (ctl.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d     = '0;
                res_mux_d = 2'd0;
                fail_d    = 1'b0;
                state_d   = S_INIT;
            end
            S_INIT:  state_d = S_MULT;
            S_MULT:  state_d = S_ADD;
            S_ADD:   state_d = S_CHECK;
            S_CHECK: begin
                if (ctl.end_signal) begin
                    // All PUs zero leaves no winner: report index 0 as failed.
                    state_d   = S_DONE;
                    res_mux_d = winner;
                    fail_d    = all_zero;
                end else if (timeout) begin
                    state_d   = S_DONE;
                    res_mux_d = 2'd0;
                    fail_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_MULT;
                end
            end
            S_DONE: begin
                if (ctl.start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: Moore enables per state, plus the CHECK feedback load.
    always_comb begin
        ctl.b_regs_en       = 1'b0;
        ctl.a_regs_en       = 1'b0;
        ctl.a_muxs          = 1'b0;
        ctl.pu_mult_regs_en = 1'b0;
        ctl.pu_add_regs_en  = 1'b0;
        case (state_q)
            S_LOAD: ctl.b_regs_en = 1'b1;
            S_INIT: begin
                ctl.a_regs_en = 1'b1;
                ctl.a_muxs    = 1'b1;
            end
            S_MULT: ctl.pu_mult_regs_en = 1'b1;
            S_ADD:  ctl.pu_add_regs_en  = 1'b1;
            // Feed PU outputs back into A only when another iteration follows.
            S_CHECK: ctl.a_regs_en = !ctl.end_signal && !timeout;
            default: ;
        endcase
    end

    assign ctl.res_mux = res_mux_q;
    assign ctl.fail    = fail_q;
    assign ctl.done    = (state_q == S_DONE);
    assign ctl.busy    = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
